// File: rtl/ip_amba_axi_slave_mem.sv
// ip_amba_axi_slave_mem: memory-backed AXI4 slave that terminates AW, W, B, AR and R.
// Latency: AW/AR accepted at edge N gives WREADY/RVALID from N+1; WLAST accepted at M gives BVALID from M+1.
// Backpressure: BVALID/BRESP and RDATA/RRESP/RLAST are held until their handshake; AWREADY/ARREADY stay low while busy.
// Ports: ACLK, ARESETn (async, active low); AW*/W*/B* write channels; AR*/R* read channels.
// Optional: define IP_AMBA_AXI_SLAVE_WRAP_EN to support WRAP bursts; without it WRAP returns SLVERR.
module ip_amba_axi_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                    ACLK,
   input  logic                    ARESETn,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);

   localparam int STRB_W  = DATA_WIDTH / 8;
   localparam int SZ      = $clog2(STRB_W);
   localparam int AW_BITS = $clog2(MEM_DEPTH);
   localparam logic [2:0] SIZE_OK = 3'(SZ);
   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef IP_AMBA_AXI_SLAVE_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef logic [AW_BITS-1:0] widx_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   // Request is rejected for wrong beat size, reserved burst, or an unsupported/illegal WRAP.
   function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                      input logic [7:0] len, input logic [SZ-1:0] lo);
      logic wrap_ok;
      wrap_ok = WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) && (lo == '0);
      return (size != SIZE_OK) || (burst == 2'b11) || (burst == B_WRAP && !wrap_ok);
   endfunction

   // WRAP: len+1 is a power of two, so len itself is the mask of the in-block word bits.
   function automatic widx_t next_idx(input widx_t idx, input logic [1:0] burst, input logic [7:0] len);
      widx_t mask;
      mask = widx_t'(len);
      case (burst)
         B_FIXED: return idx;
         B_WRAP:  return (idx & ~mask) | ((idx + widx_t'(1)) & mask);
         default: return idx + widx_t'(1);
      endcase
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   wstate_t               w_state, w_next;
   rstate_t               r_state, r_next;
   logic                  rst_done;

   logic [ID_WIDTH-1:0]   w_id, r_id;
   widx_t                 w_idx, r_idx;
   logic [7:0]            w_len, r_len, r_cnt;
   logic [1:0]            w_burst, r_burst;
   logic                  w_err, r_err;
   logic [8:0]            w_cnt;       // bit 8 is a sticky overflow past 256 beats
   logic [8:0]            w_cnt_inc;
   logic                  w_in_range;
   logic [DATA_WIDTH-1:0] r_dat;
   logic                  r_last;

   logic                  aw_hs, w_hs, ar_hs, r_hs;
   logic                  ar_err;
   widx_t                 aw_idx, ar_idx, r_idx_nxt;
   logic                  unused_addr;

   assign aw_idx      = AWADDR[AW_BITS+SZ-1:SZ];
   assign ar_idx      = ARADDR[AW_BITS+SZ-1:SZ];
   assign unused_addr = ^{AWADDR[ADDR_WIDTH-1:AW_BITS+SZ], ARADDR[ADDR_WIDTH-1:AW_BITS+SZ]};

   assign aw_hs = AWVALID && AWREADY;
   assign w_hs  = WVALID && WREADY;
   assign ar_hs = ARVALID && ARREADY;
   assign r_hs  = RVALID && RREADY;

   assign w_cnt_inc  = w_cnt + 9'd1;
   assign w_in_range = !w_cnt[8] && (w_cnt[7:0] <= w_len);
   assign ar_err     = burst_err(ARSIZE, ARBURST, ARLEN, ARADDR[SZ-1:0]);
   assign r_idx_nxt  = next_idx(r_idx, r_burst, r_len);

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rst_done <= 1'b0;
         w_state  <= W_IDLE;
         r_state  <= R_IDLE;
      end else begin
         rst_done <= 1'b1;
         w_state  <= w_next;
         r_state  <= r_next;
      end
   end

   always_comb begin
      w_next  = w_state;
      AWREADY = 1'b0;
      WREADY  = 1'b0;
      BVALID  = 1'b0;
      case (w_state)
         W_IDLE: begin
            AWREADY = rst_done;
            if (AWVALID && rst_done) w_next = W_DATA;
         end
         W_DATA: begin
            WREADY = 1'b1;
            if (WVALID && WLAST) w_next = W_RESP;
         end
         W_RESP: begin
            BVALID = 1'b1;
            if (BREADY) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next  = r_state;
      ARREADY = 1'b0;
      RVALID  = 1'b0;
      case (r_state)
         R_IDLE: begin
            ARREADY = rst_done;
            if (ARVALID && rst_done) r_next = R_DATA;
         end
         R_DATA: begin
            RVALID = 1'b1;
            if (RREADY && r_last) r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   assign BID   = w_id;
   assign BRESP = (w_state == W_RESP && w_err) ? RESP_SLVERR : 2'b00;
   assign RID   = r_id;
   assign RDATA = r_dat;
   assign RRESP = (r_state == R_DATA && r_err) ? RESP_SLVERR : 2'b00;
   assign RLAST = r_last;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         w_id    <= '0;
         w_idx   <= '0;
         w_len   <= '0;
         w_burst <= '0;
         w_err   <= 1'b0;
         w_cnt   <= '0;
      end else if (aw_hs) begin
         w_id    <= AWID;
         w_idx   <= aw_idx;
         w_len   <= AWLEN;
         w_burst <= AWBURST;
         w_err   <= burst_err(AWSIZE, AWBURST, AWLEN, AWADDR[SZ-1:0]);
         w_cnt   <= '0;
      end else if (w_hs) begin
         w_idx <= next_idx(w_idx, w_burst, w_len);
         w_cnt <= {w_cnt[8] | w_cnt_inc[8], w_cnt_inc[7:0]};
         // Excess beats and a WLAST that disagrees with AWLEN both poison the response.
         if (!w_in_range || (WLAST && w_cnt != {1'b0, w_len})) w_err <= 1'b1;
      end
   end

   // Storage is never reset; writes only occur in W_DATA, which reset forces out of.
   always_ff @(posedge ACLK) begin
      if (w_hs && !w_err && w_in_range) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (WSTRB[b]) mem[w_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
         end
      end
   end

   // RDATA is a register loaded from the array, so a write on the load edge is not seen.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_id    <= '0;
         r_idx   <= '0;
         r_len   <= '0;
         r_burst <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
         r_dat   <= '0;
         r_last  <= 1'b0;
      end else if (ar_hs) begin
         r_id    <= ARID;
         r_idx   <= ar_idx;
         r_len   <= ARLEN;
         r_burst <= ARBURST;
         r_err   <= ar_err;
         r_cnt   <= '0;
         r_dat   <= ar_err ? '0 : mem[ar_idx];
         r_last  <= (ARLEN == 8'd0);
      end else if (r_hs) begin
         if (r_last) begin
            r_last <= 1'b0;
         end else begin
            r_idx  <= r_idx_nxt;
            r_cnt  <= r_cnt + 8'd1;
            r_dat  <= r_err ? '0 : mem[r_idx_nxt];
            r_last <= ((r_cnt + 8'd1) == r_len);
         end
      end
   end

endmodule

// File: tb/tb_ip_amba_axi_slave_mem.sv
module tb_ip_amba_axi_slave_mem;

   localparam int DEPTH = 256;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [3:0]  AWID = '0;
   logic [31:0] AWADDR = '0;
   logic [7:0]  AWLEN = '0;
   logic [2:0]  AWSIZE = '0;
   logic [1:0]  AWBURST = '0;
   logic        AWVALID = 1'b0;
   logic        AWREADY;
   logic [31:0] WDATA = '0;
   logic [3:0]  WSTRB = '0;
   logic        WLAST = 1'b0;
   logic        WVALID = 1'b0;
   logic        WREADY;
   logic [3:0]  BID;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY = 1'b0;
   logic [3:0]  ARID = '0;
   logic [31:0] ARADDR = '0;
   logic [7:0]  ARLEN = '0;
   logic [2:0]  ARSIZE = '0;
   logic [1:0]  ARBURST = '0;
   logic        ARVALID = 1'b0;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY = 1'b0;

   ip_amba_axi_slave_mem #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(DEPTH)
   ) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   always #5 ACLK = ~ACLK;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mm [DEPTH];      // reference memory image
   logic [31:0] wdat [300];
   logic [3:0]  wstb [300];
   logic [31:0] sw_addr, sw_data;

   // Reference rules: error when size is not 4 bytes, burst reserved, or WRAP unsupported/illegal.
   function automatic bit m_err(logic [2:0] size, logic [1:0] burst, logic [7:0] len, logic [31:0] addr);
      bit e;
      e = (size != 3'd2) || (burst == 2'b11);
      if (burst == 2'b10) begin
`ifdef IP_AMBA_AXI_SLAVE_WRAP_EN
         if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (addr % 4) != 0) e = 1'b1;
`else
         e = 1'b1;
`endif
      end
      return e;
   endfunction

   // Word touched by beat i of a burst, from plain arithmetic on word numbers.
   function automatic int m_word(logic [31:0] addr, logic [7:0] len, logic [1:0] burst, int i);
      int w0, n, base;
      w0 = int'((addr / 4) % DEPTH);
      n  = int'(len) + 1;
      if (burst == 2'b00) return w0;
      if (burst == 2'b10) begin
         base = (w0 / n) * n;
         return base + (w0 - base + i) % n;
      end
      return (w0 + i) % DEPTH;
   endfunction

   function automatic logic sig(int sel);
      case (sel)
         0: return AWREADY;
         1: return WREADY;
         2: return BVALID;
         3: return ARREADY;
         default: return RVALID;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; polls a DUT handshake signal with a cycle budget.
   task automatic wait_hi(input int sel, input string tag);
      int n;
      n = 0;
      while (sig(sel) !== 1'b1 && n < 300) begin
         n++;
         @(negedge ACLK);
      end
      chk(tag, 64'(sig(sel)), 64'd1);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nb, input int bdly);
      bit e;
      logic [1:0] eresp;
      int w;
      e = m_err(size, burst, len, addr);
      eresp = (e || nb != int'(len) + 1) ? 2'b10 : 2'b00;
      AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
      @(negedge ACLK);
      wait_hi(0, "awready");
      @(posedge ACLK); #1 AWVALID = 1'b0;
      for (int i = 0; i < nb; i++) begin
         WDATA = wdat[i]; WSTRB = wstb[i]; WLAST = (i == nb - 1); WVALID = 1'b1;
         @(negedge ACLK);
         if (i == 0) chk("wready_latency", 64'(WREADY), 64'd1);
         wait_hi(1, "wready");
         @(posedge ACLK); #1;
         if (!e && i <= int'(len)) begin
            w = m_word(addr, len, burst, i);
            for (int b = 0; b < 4; b++) if (wstb[i][b]) mm[w][b*8 +: 8] = wdat[i][b*8 +: 8];
         end
      end
      WVALID = 1'b0; WLAST = 1'b0;
      @(negedge ACLK);
      chk("bvalid_latency", 64'(BVALID), 64'd1);
      for (int k = 0; k < bdly; k++) begin
         chk("bvalid_hold", 64'(BVALID), 64'd1);
         chk("bresp_hold", 64'(BRESP), 64'(eresp));
         chk("awready_busy", 64'(AWREADY), 64'd0);
         @(negedge ACLK);
      end
      wait_hi(2, "bvalid");
      BREADY = 1'b1;
      chk("bresp", 64'(BRESP), 64'(eresp));
      chk("bid", 64'(BID), 64'(id));
      @(posedge ACLK); #1 BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int stall_beat, input int stall_n, input bit stall_wr);
      bit e;
      logic [31:0] exp_d [$];
      e = m_err(size, burst, len, addr);
      for (int i = 0; i <= int'(len); i++) exp_d.push_back(e ? 32'd0 : mm[m_word(addr, len, burst, i)]);
      ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
      @(negedge ACLK);
      wait_hi(3, "arready");
      @(posedge ACLK); #1 ARVALID = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         @(negedge ACLK);
         if (i == 0) chk("rvalid_latency", 64'(RVALID), 64'd1);
         if (i == stall_beat) begin
            for (int k = 0; k < stall_n; k++) begin
               chk("rvalid_hold", 64'(RVALID), 64'd1);
               chk("rdata_hold", 64'(RDATA), 64'(exp_d[i]));
               if (stall_wr && k == 0) begin
                  @(posedge ACLK); #1;
                  wdat[0] = sw_data; wstb[0] = 4'hF;
                  do_write(4'h1, sw_addr, 8'd0, 3'd2, 2'b01, 1, 0);
               end
               @(negedge ACLK);
            end
         end
         wait_hi(4, "rvalid");
         RREADY = 1'b1;
         chk("rdata", 64'(RDATA), 64'(exp_d[i]));
         chk("rresp", 64'(RRESP), e ? 64'd2 : 64'd0);
         chk("rlast", 64'(RLAST), 64'(i == int'(len)));
         chk("rid", 64'(RID), 64'(id));
         @(posedge ACLK); #1 RREADY = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [31:0] addr;
      int          nb, pick;

      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      chk("rst_awready", 64'(AWREADY), 64'd0);
      chk("rst_arready", 64'(ARREADY), 64'd0);
      chk("rst_wready", 64'(WREADY), 64'd0);
      chk("rst_bvalid", 64'(BVALID), 64'd0);
      chk("rst_rvalid", 64'(RVALID), 64'd0);
      chk("rst_rdata", 64'(RDATA), 64'd0);
      chk("rst_rlast", 64'(RLAST), 64'd0);
      @(posedge ACLK); #1 ARESETn = 1'b1;
      @(negedge ACLK);
      chk("awready_before_done", 64'(AWREADY), 64'd0);
      chk("arready_before_done", 64'(ARREADY), 64'd0);
      @(negedge ACLK);
      chk("awready_after_done", 64'(AWREADY), 64'd1);
      chk("arready_after_done", 64'(ARREADY), 64'd1);
      @(posedge ACLK); #1;

      // Fill the whole array so every later read has a known reference value.
      for (int i = 0; i < DEPTH; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      do_write(4'h3, 32'h0, 8'd255, 3'd2, 2'b01, DEPTH, 0);

      // INCR 4 words at 0x10, response held under BREADY backpressure.
      wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
      for (int i = 0; i < 4; i++) wstb[i] = 4'hF;
      do_write(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 4, 3);
      do_read(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, 99, 0, 1'b0);

      // Partial strobe over an all-ones word.
      wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
      do_write(4'h2, 32'h30, 8'd0, 3'd2, 2'b01, 1, 0);
      wdat[0] = 32'hAABB_CCDD; wstb[0] = 4'b0101;
      do_write(4'h2, 32'h30, 8'd0, 3'd2, 2'b01, 1, 0);
      do_read(4'h2, 32'h30, 8'd0, 3'd2, 2'b01, 99, 0, 1'b0);

      // FIXED burst: only the last beat survives at 0x20.
      wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3;
      for (int i = 0; i < 3; i++) wstb[i] = 4'hF;
      do_write(4'h4, 32'h20, 8'd2, 3'd2, 2'b00, 3, 0);
      do_read(4'h4, 32'h20, 8'd2, 3'd2, 2'b01, 99, 0, 1'b0);

      // Narrow size is an error and leaves memory alone; reserved burst reads zeros.
      wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
      do_write(4'h6, 32'h40, 8'd0, 3'd1, 2'b01, 1, 0);
      do_read(4'h6, 32'h40, 8'd0, 3'd2, 2'b01, 99, 0, 1'b0);
      do_read(4'h7, 32'h50, 8'd1, 3'd2, 2'b11, 99, 0, 1'b0);

      // RREADY stalled on beat 1 while a write hits that pending word.
      sw_addr = 32'h64; sw_data = $urandom;
      do_read(4'h8, 32'h60, 8'd1, 3'd2, 2'b01, 1, 5, 1'b1);
      do_read(4'h8, 32'h64, 8'd0, 3'd2, 2'b01, 99, 0, 1'b0);

      // WRAP of 4 beats at 0x08: supported only with the wrap build.
      for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
      do_write(4'h9, 32'h08, 8'd3, 3'd2, 2'b10, 4, 0);
      do_read(4'h9, 32'h00, 8'd3, 3'd2, 2'b01, 99, 0, 1'b0);
      do_read(4'h9, 32'h08, 8'd3, 3'd2, 2'b10, 99, 0, 1'b0);

      // Reset in the middle of a write burst: two beats land, FSMs abort.
      AWID = 4'h1; AWADDR = 32'h80; AWLEN = 8'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
      @(negedge ACLK);
      wait_hi(0, "awready_rst");
      @(posedge ACLK); #1 AWVALID = 1'b0;
      for (int i = 0; i < 2; i++) begin
         WDATA = $urandom; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
         @(negedge ACLK);
         wait_hi(1, "wready_rst");
         @(posedge ACLK); #1;
         mm[32 + i] = WDATA;
      end
      WVALID = 1'b0;
      ARESETn = 1'b0;
      #1;
      chk("midrst_wready", 64'(WREADY), 64'd0);
      chk("midrst_awready", 64'(AWREADY), 64'd0);
      chk("midrst_bvalid", 64'(BVALID), 64'd0);
      @(posedge ACLK); #1 ARESETn = 1'b1;
      @(posedge ACLK); #1;
      do_read(4'h1, 32'h80, 8'd1, 3'd2, 2'b01, 99, 0, 1'b0);

      // Randomized traffic against the reference image.
      for (int t = 0; t < 40; t++) begin
         len = 8'($urandom_range(0, 7));
         pick = $urandom_range(0, 5);
         burst = (pick == 0) ? 2'b00 : (pick == 4) ? 2'b10 : (pick == 5) ? 2'b11 : 2'b01;
         size = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         nb = int'(len) + 1;
         pick = $urandom_range(0, 5);
         if (pick == 0) nb = int'(len) + 2;
         if (pick == 1 && len > 0) nb = int'(len);
         for (int i = 0; i < nb; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
         do_write(4'($urandom), addr, len, size, burst, nb, $urandom_range(0, 2));

         len = 8'($urandom_range(0, 7));
         pick = $urandom_range(0, 5);
         burst = (pick == 0) ? 2'b00 : (pick == 4) ? 2'b10 : (pick == 5) ? 2'b11 : 2'b01;
         size = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
         if ($urandom_range(0, 1) == 0) addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         do_read(4'($urandom), addr, len, size, burst,
                 $urandom_range(0, int'(len)), $urandom_range(0, 3), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
